// File: rtl/tl_cntr_multi_pkg.sv
// Shared definitions for the multi-direction traffic-light controller:
// phase encodings, lamp codes and small helpers.
package tl_cntr_multi_pkg;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_ALLRED = 2'b10
  } phase_e;

  localparam logic [1:0] TL_RED = 2'b00;
  localparam logic [1:0] TL_YEL = 2'b01;
  localparam logic [1:0] TL_GRN = 2'b10;

  // Width of a direction index; a 2-approach junction still needs one bit.
  function automatic int dir_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Lamp shown by the approach that owns the current phase.
  function automatic logic [1:0] lamp_of(input phase_e ph);
    case (ph)
      PH_GREEN:  return TL_GRN;
      PH_YELLOW: return TL_YEL;
      default:   return TL_RED;
    endcase
  endfunction

endpackage

// File: rtl/tl_cntr_multi_rr_pick.sv
// Combinational round-robin picker: finds the first waiting approach after
// the current one (wrapping) and flags whether anyone else is waiting.
module tl_rr_pick
  import tl_cntr_multi_pkg::*;
#(
  parameter int N_DIR = 2,
  localparam int DIR_W = dir_w(N_DIR)
) (
  input  logic [N_DIR-1:0] sensor,
  input  logic [DIR_W-1:0] cur_dir,
  output logic [DIR_W-1:0] next_dir,
  output logic             other_req
);

  logic             found;
  logic [DIR_W-1:0] cand;

  // Scan cur_dir+1 .. cur_dir+N_DIR-1 (mod N_DIR); own approach is excluded.
  always_comb begin
    next_dir  = cur_dir;
    other_req = 1'b0;
    found     = 1'b0;
    cand      = cur_dir;
    for (int k = 1; k < N_DIR; k++) begin
      cand = DIR_W'((int'(cur_dir) + k) % N_DIR);
      if (!found && sensor[cand]) begin
        next_dir  = cand;
        other_req = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tl_cntr_multi.sv
// Multi-direction traffic-light controller. Serves N_DIR approaches in
// round-robin order with sensor-driven green bounded by min/max timers,
// a timed yellow and an optional all-red clearance. All outputs are flops.
module tl_cntr_multi
  import tl_cntr_multi_pkg::*;
#(
  parameter int N_DIR       = 2,
  parameter int CNT_W       = 8,
  parameter int T_GREEN_MIN = 4,
  parameter int T_GREEN_MAX = 16,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 1,
  localparam int DIR_W = dir_w(N_DIR)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_DIR-1:0]   sensor,
  output logic [2*N_DIR-1:0] light,
  output logic [DIR_W-1:0]   cur_dir,
  output logic [1:0]         phase
);

  // Last timer value of each phase (timer counts 0 .. T-1).
  localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(T_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(T_GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] RED_LAST  = CNT_W'((T_ALLRED > 0) ? T_ALLRED - 1 : 0);
  localparam logic [2*N_DIR-1:0] LIGHT_RST = {{(2*N_DIR-2){1'b0}}, TL_GRN};

  phase_e             phase_q, phase_d;
  logic [DIR_W-1:0]   cur_dir_q, cur_dir_d;
  logic [DIR_W-1:0]   next_dir_q, next_dir_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [2*N_DIR-1:0] light_q, light_d;

  logic [DIR_W-1:0]   pick_dir;
  logic               other_req;

  tl_rr_pick #(
    .N_DIR (N_DIR)
  ) u_pick (
    .sensor    (sensor),
    .cur_dir   (cur_dir_q),
    .next_dir  (pick_dir),
    .other_req (other_req)
  );

  // Phase sequencing, phase timer and next-direction latch.
  always_comb begin
    phase_d    = phase_q;
    cur_dir_d  = cur_dir_q;
    next_dir_d = next_dir_q;
    timer_d    = timer_q + 1'b1;
    case (phase_q)
      PH_GREEN: begin
        if (other_req &&
            ((timer_q >= GMIN_LAST && !sensor[cur_dir_q]) || timer_q >= GMAX_LAST)) begin
          phase_d    = PH_YELLOW;
          timer_d    = '0;
          next_dir_d = pick_dir;
        end else if (timer_q >= GMAX_LAST) begin
          timer_d = GMAX_LAST;
        end
      end
      PH_YELLOW: begin
        if (timer_q >= YEL_LAST) begin
          timer_d = '0;
          if (T_ALLRED == 0) begin
            phase_d   = PH_GREEN;
            cur_dir_d = next_dir_q;
          end else begin
            phase_d = PH_ALLRED;
          end
        end
      end
      PH_ALLRED: begin
        if (timer_q >= RED_LAST) begin
          timer_d   = '0;
          phase_d   = PH_GREEN;
          cur_dir_d = next_dir_q;
        end
      end
      default: begin
        phase_d   = PH_GREEN;
        cur_dir_d = '0;
        timer_d   = '0;
      end
    endcase
  end

  // Lamp decode from the next state so the lamp flops switch with phase/cur_dir.
  always_comb begin
    light_d = '0;
    for (int i = 0; i < N_DIR; i++) begin
      if (cur_dir_d == DIR_W'(i)) begin
        light_d[2*i +: 2] = lamp_of(phase_d);
      end
    end
  end

  // State and output registers; reset drops any latched next direction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q    <= PH_GREEN;
      cur_dir_q  <= '0;
      next_dir_q <= '0;
      timer_q    <= '0;
      light_q    <= LIGHT_RST;
    end else begin
      phase_q    <= phase_d;
      cur_dir_q  <= cur_dir_d;
      next_dir_q <= next_dir_d;
      timer_q    <= timer_d;
      light_q    <= light_d;
    end
  end

  assign light   = light_q;
  assign cur_dir = cur_dir_q;
  assign phase   = phase_q;

endmodule

// File: tb/tb_tl_cntr_multi.sv
// Bench for tl_cntr_multi: a 4-approach instance against a phase/elapsed-time
// reference model, and a 2-approach legacy-configured instance against a
// four-state legacy controller description. Expected outputs are queued per
// clock by the driver and popped by an independent monitor.
module tb_tl_cntr_multi;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] sensor4 = '0;
  logic [1:0] sensor2 = '0;

  logic [7:0] light4;
  logic [1:0] dir4;
  logic [1:0] ph4;
  logic [3:0] light2;
  logic       dir2;
  logic [1:0] ph2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tl_cntr_multi #(
    .N_DIR(4), .CNT_W(8), .T_GREEN_MIN(4), .T_GREEN_MAX(8), .T_YELLOW(2), .T_ALLRED(1)
  ) u4 (
    .clk(clk), .reset_n(reset_n), .sensor(sensor4),
    .light(light4), .cur_dir(dir4), .phase(ph4)
  );

  tl_cntr_multi #(
    .N_DIR(2), .CNT_W(8), .T_GREEN_MIN(1), .T_GREEN_MAX(255), .T_YELLOW(1), .T_ALLRED(0)
  ) u2 (
    .clk(clk), .reset_n(reset_n), .sensor(sensor2),
    .light(light2), .cur_dir(dir2), .phase(ph2)
  );

  typedef struct { logic [7:0] light; logic [1:0] dir; logic [1:0] ph; } exp4_t;
  typedef struct { logic [3:0] light; logic dir; logic [1:0] ph; } exp2_t;
  typedef struct { int dir; int ph; int age; int nxt; } mst_t;

  exp4_t q4[$];
  exp2_t q2[$];
  mst_t  m4;
  int    lg;   // legacy state: 0 G0, 1 Y0, 2 G1, 3 Y1

  // Generic model: ph 0 green, 1 yellow, 2 all-red; age = cycles already spent
  // in the phase before this edge.
  function automatic mst_t gen_step(mst_t m, logic [7:0] s, int n, int mn, int mx,
                                    int ty, int ta);
    mst_t r;
    bit   other;
    bit   found;
    r = m;
    other = 1'b0;
    found = 1'b0;
    for (int j = 0; j < n; j++) if (j != m.dir && s[j]) other = 1'b1;
    case (m.ph)
      0: begin
        if (other && ((m.age + 1 >= mn && !s[m.dir]) || m.age + 1 >= mx)) begin
          for (int k = 1; k < n; k++) begin
            if (!found && s[(m.dir + k) % n]) begin
              r.nxt = (m.dir + k) % n;
              found = 1'b1;
            end
          end
          r.ph  = 1;
          r.age = 0;
        end else begin
          r.age = m.age + 1;
        end
      end
      1: begin
        if (m.age + 1 >= ty) begin
          r.age = 0;
          if (ta == 0) begin r.ph = 0; r.dir = m.nxt; end
          else r.ph = 2;
        end else r.age = m.age + 1;
      end
      default: begin
        if (m.age + 1 >= ta) begin
          r.ph = 0; r.dir = m.nxt; r.age = 0;
        end else r.age = m.age + 1;
      end
    endcase
    return r;
  endfunction

  function automatic exp4_t exp_of(mst_t m);
    exp4_t e;
    e.light = '0;
    if (m.ph == 0) e.light[2*m.dir +: 2] = 2'b10;
    else if (m.ph == 1) e.light[2*m.dir +: 2] = 2'b01;
    e.dir = 2'(m.dir);
    e.ph  = 2'(m.ph);
    return e;
  endfunction

  // Legacy two-sensor controller: green approach yields only when the other
  // one is waiting and its own sensor is clear; one yellow cycle.
  function automatic int leg_step(int st, logic [1:0] s);
    case (st)
      0:       return (s == 2'b10) ? 1 : 0;
      1:       return 2;
      2:       return (s == 2'b01) ? 3 : 2;
      default: return 0;
    endcase
  endfunction

  function automatic exp2_t leg_exp(int st);
    exp2_t e;
    case (st)
      0:       begin e.light = 4'b0010; e.dir = 1'b0; e.ph = 2'b00; end
      1:       begin e.light = 4'b0001; e.dir = 1'b0; e.ph = 2'b01; end
      2:       begin e.light = 4'b1000; e.dir = 1'b1; e.ph = 2'b00; end
      default: begin e.light = 4'b0100; e.dir = 1'b1; e.ph = 2'b01; end
    endcase
    return e;
  endfunction

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%b exp=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk4(input string name, input logic [7:0] l, input logic [1:0] d,
                      input logic [1:0] p);
    cmp({name, "_light"}, light4, l);
    cmp({name, "_dir"}, {6'b0, dir4}, {6'b0, d});
    cmp({name, "_phase"}, {6'b0, ph4}, {6'b0, p});
  endtask

  // Called at a falling edge: drive one cycle of stimulus and queue the
  // response expected after the next rising edge.
  task automatic cycle(input logic [3:0] s4);
    sensor4 = s4;
    if ($urandom_range(0, 1) == 1) sensor2 = 2'($urandom_range(0, 3));
    m4 = gen_step(m4, {4'b0, s4}, 4, 4, 8, 2, 1);
    q4.push_back(exp_of(m4));
    lg = leg_step(lg, sensor2);
    q2.push_back(leg_exp(lg));
    @(negedge clk);
  endtask

  // Asynchronous reset mid-cycle, checked immediately, released one cycle later.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk4("rst", 8'b0000_0010, 2'd0, 2'b00);
    cmp("rst2_light", {4'b0, light2}, 8'b0000_0010);
    cmp("rst2_dir", {7'b0, dir2}, 8'd0);
    cmp("rst2_phase", {6'b0, ph2}, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;
    m4 = '{dir: 0, ph: 0, age: 0, nxt: 0};
    lg = 0;
  endtask

  exp4_t e4;
  exp2_t e2;

  // Monitor: compare queued expectations and sweep lamp safety every cycle.
  always @(posedge clk) begin
    int nonred;
    bit bad;
    #1;
    if (q4.size() > 0) begin
      e4 = q4.pop_front();
      cmp("u4_light", light4, e4.light);
      cmp("u4_dir", {6'b0, dir4}, {6'b0, e4.dir});
      cmp("u4_phase", {6'b0, ph4}, {6'b0, e4.ph});
    end
    if (q2.size() > 0) begin
      e2 = q2.pop_front();
      cmp("u2_light", {4'b0, light2}, {4'b0, e2.light});
      cmp("u2_dir", {7'b0, dir2}, {7'b0, e2.dir});
      cmp("u2_phase", {6'b0, ph2}, {6'b0, e2.ph});
    end
    nonred = 0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (light4[2*i +: 2] == 2'b11) bad = 1'b1;
      if (light4[2*i +: 2] != 2'b00) nonred++;
    end
    for (int i = 0; i < 2; i++) begin
      if (light2[2*i +: 2] == 2'b11) bad = 1'b1;
    end
    if (nonred > 1) bad = 1'b1;
    if ((light2[1:0] != 2'b00) && (light2[3:2] != 2'b00)) bad = 1'b1;
    cmp("lamp_safety", {7'b0, bad}, 8'd0);
  end

  initial begin
    logic [3:0] rs;
    rs = '0;
    m4 = '{dir: 0, ph: 0, age: 0, nxt: 0};
    lg = 0;
    repeat (2) @(negedge clk);
    do_reset();

    // Green holds with nobody else waiting.
    repeat (6) cycle(4'b0000);
    chk4("hold_idle", 8'b0000_0010, 2'd0, 2'b00);
    repeat (6) cycle(4'b0001);
    chk4("hold_own", 8'b0000_0010, 2'd0, 2'b00);

    // Reach yellow, then reset asynchronously in the middle of it.
    do_reset();
    repeat (4) cycle(4'b0100);
    chk4("pre_rst_yel", 8'b0000_0001, 2'd0, 2'b01);
    cycle(4'b0100);
    do_reset();
    repeat (4) cycle(4'b0000);
    chk4("post_rst_hold", 8'b0000_0010, 2'd0, 2'b00);

    // Minimum green: 4 green, 2 yellow, 1 all-red, then approach 2.
    do_reset();
    repeat (3) cycle(4'b0100);
    chk4("min_green", 8'b0000_0010, 2'd0, 2'b00);
    cycle(4'b0100);
    chk4("min_yellow", 8'b0000_0001, 2'd0, 2'b01);
    repeat (2) cycle(4'b0100);
    chk4("min_allred", 8'b0000_0000, 2'd0, 2'b10);
    cycle(4'b0100);
    chk4("min_next", 8'b0010_0000, 2'd2, 2'b00);

    // Maximum green with own sensor high: 8 green cycles, then approach 1.
    do_reset();
    repeat (7) cycle(4'b0011);
    chk4("max_green", 8'b0000_0010, 2'd0, 2'b00);
    cycle(4'b0011);
    chk4("max_yellow", 8'b0000_0001, 2'd0, 2'b01);
    repeat (3) cycle(4'b0011);
    chk4("max_next", 8'b0000_1000, 2'd1, 2'b00);

    // Round-robin from approach 2 skips idle 3, serves 0 then 1.
    do_reset();
    repeat (7) cycle(4'b0100);
    chk4("rr_on2", 8'b0010_0000, 2'd2, 2'b00);
    repeat (7) cycle(4'b0011);
    chk4("rr_to0", 8'b0000_0010, 2'd0, 2'b00);
    repeat (11) cycle(4'b0011);
    chk4("rr_to1", 8'b0000_1000, 2'd1, 2'b00);

    // Latch stability: approach 2 chosen, its sensor drops during yellow.
    do_reset();
    repeat (4) cycle(4'b0100);
    repeat (3) cycle(4'b1000);
    chk4("latch_on2", 8'b0010_0000, 2'd2, 2'b00);
    repeat (7) cycle(4'b1000);
    chk4("latch_to3", 8'b1000_0000, 2'd3, 2'b00);

    // Randomised traffic with patterns held for a few cycles.
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) rs = 4'($urandom_range(0, 15));
      cycle(rs);
    end

    repeat (2) @(negedge clk);
    cmp("queue_drain", 8'(q4.size() + q2.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
